vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, meaning pixel clocks per line.
REQ-002 The block SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 The block SHALL have parameter H_ACT_START, default 144, meaning first active h_count (hsync 96 plus back porch 48).
REQ-004 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-005 The block SHALL have parameter V_ACT_START, default 35, meaning first active v_count (vsync 2 plus back porch 33).
REQ-006 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-007 The block SHALL have port clk, input, 1 bit: pixel clock, the only clock.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port vga_hs, input, 1 bit: active-low horizontal sync, synchronous to clk.
REQ-010 The block SHALL have port vga_vs, input, 1 bit: active-low vertical sync, synchronous to clk.
REQ-011 The block SHALL have port h_count, output, 10 bits: recovered pixel position within the line.
REQ-012 The block SHALL have port v_count, output, 10 bits: recovered line position within the frame.
REQ-013 The block SHALL have port locked, output, 1 bit: high while the timing is verified.
REQ-014 The block SHALL have port active, output, 1 bit: data-enable for the visible region.
REQ-015 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at locked frame origin.
REQ-016 The block SHALL have port err_count, output, 8 bits: saturating timing-error count.

Function
REQ-017 The block SHALL register vga_hs/vga_vs into hs_d/vs_d each clk; an HS event is a clk edge sampling vga_hs=0 with hs_d=1; a VS event is the same for vga_vs.
REQ-018 On an HS event h_count SHALL load 0; otherwise h_count SHALL increment by 1 per clk and saturate at 1023.
REQ-019 A VS event SHALL set a pending flag; the first HS event at or after the VS event (same edge included) is a V-reload: v_count loads 0 and pending clears.
REQ-020 On a non-reload HS event v_count SHALL increment by 1 and saturate at 1023.
REQ-021 Line good: at an HS event, prior h_count equals H_TOTAL-1; line error: an HS event with any other h_count, or h_count reaching H_TOTAL with no HS event (timeout, flagged once per line).
REQ-022 Frame good: at a V-reload, prior v_count equals V_TOTAL-1 and no line error since the previous V-reload.
REQ-023 The FSM SHALL have states SEARCH, MEASURE and LOCKED; locked SHALL be 1 only in LOCKED.
REQ-024 SEARCH SHALL go to MEASURE on the first V-reload.
REQ-025 MEASURE SHALL go to LOCKED on a V-reload with frame good, and SHALL stay in MEASURE on a V-reload with frame bad.
REQ-026 LOCKED SHALL go to SEARCH on any line error.
REQ-027 LOCKED SHALL go to MEASURE on a V-reload with frame bad.
REQ-028 err_count SHALL increment by 1 for each LOCKED-to-SEARCH or LOCKED-to-MEASURE transition and saturate at 255.
REQ-029 frame_start SHALL be registered and high for exactly the one cycle after a V-reload whose resulting state is LOCKED; that cycle shows h_count=0 and v_count=0.
REQ-030 active SHALL be combinational from registered state: locked AND H_ACT_START<=h_count<H_ACT_START+H_ACTIVE AND V_ACT_START<=v_count<V_ACT_START+V_ACTIVE.
REQ-031 If a line error and a V-reload occur on the same edge in LOCKED, the line-error transition (to SEARCH) SHALL win, and err_count SHALL increment once.
REQ-032 vga_hs/vga_vs held low continuously SHALL produce no further events; the timeout SHALL still drive the line error.

Reset
REQ-033 While reset=1, regardless of clk: h_count=0, v_count=0, locked=0, active=0, frame_start=0, err_count=0, pending=0, state=SEARCH, and hs_d=vs_d=1 so no false event follows reset release.
REQ-034 Reset asserted mid-frame SHALL abandon lock immediately; re-lock SHALL require SEARCH to MEASURE to LOCKED again, i.e. one full good frame after the first V-reload.

Verification
REQ-035 Standard 640x480 timing (800x525, hsync 96, vsync 2 lines aligned to the HS edge) from reset: locked rises at the second V-reload, frame_start pulses once, err_count=0.
REQ-036 Locked, one line 799 clocks long: locked=0 on the next HS event, err_count=1, re-lock after two further V-reloads.
REQ-037 Locked, hsync stops: at h_count=800 locked=0, err_count=1, h_count saturates at 1023.
REQ-038 Locked, a frame of 524 lines: V-reload to MEASURE, locked=0, err_count=1, no frame_start; the next 525-line frame relocks.
REQ-039 VS falls 10 clocks before an HS edge: v_count=0 loads on that HS edge, not earlier; active first high at h_count=144, v_count=35.
REQ-040 Reset pulsed mid-line while locked: all outputs 0 at once, and the first vga_hs sample after release causes no HS event unless it is a real falling edge.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered timing outputs of vga_sync_decoder
//
// vga_hs, vga_vs   : active-low sync, driven by the video source (master)
// h_count, v_count : recovered pixel / line position
// locked           : timing verified
// active           : visible-region data enable
// frame_start      : one-cycle pulse at locked frame origin
// err_count        : saturating count of lock losses
interface vga_sync_decoder_if;
    logic       vga_hs;
    logic       vga_vs;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       locked;
    logic       active;
    logic       frame_start;
    logic [7:0] err_count;

    modport master (
        output vga_hs, vga_vs,
        input  h_count, v_count, locked, active, frame_start, err_count
    );

    modport slave (
        input  vga_hs, vga_vs,
        output h_count, v_count, locked, active, frame_start, err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel/line position and lock from VGA hsync/vsync
//
// clk   : pixel clock
// reset : asynchronous, active-high
// bus   : vga_sync_decoder_if.slave (sync inputs, counters, lock, active, frame_start, err_count)
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480
) (
    input  logic                clk,
    input  logic                reset,
    vga_sync_decoder_if.slave   bus
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LO   = 10'(H_ACT_START);
    localparam logic [9:0] H_HI   = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] V_LO   = 10'(V_ACT_START);
    localparam logic [9:0] V_HI   = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'h3ff;

    state_t     state, state_nxt;
    logic       hs_d, vs_d;
    logic [9:0] h_cnt, v_cnt;
    logic       pending;
    logic       line_bad;     // a line error since the last V-reload
    logic [7:0] err_cnt;
    logic       frame_start_r;

    logic hs_ev, vs_ev, v_reload, line_err, frame_good, err_inc;

    assign hs_ev    = !bus.vga_hs && hs_d;
    assign vs_ev    = !bus.vga_vs && vs_d;
    // A VS on the same edge as the HS counts, hence the direct vs_ev term.
    assign v_reload = hs_ev && (pending || vs_ev);
    // Timeout fires on the edge where h_count would step past the last pixel;
    // saturation keeps h_count from passing H_LAST again, so it fires once per line.
    assign line_err = hs_ev ? (h_cnt != H_LAST) : (h_cnt == H_LAST);
    // The line closed by the reload edge belongs to the frame being judged.
    assign frame_good = (v_cnt == V_LAST) && !line_bad && !line_err;

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (v_reload) state_nxt = MEASURE;
            MEASURE: if (v_reload && frame_good) state_nxt = LOCKED;
            LOCKED: begin
                // Line error takes priority over a simultaneous bad-frame reload.
                if (line_err)                     state_nxt = SEARCH;
                else if (v_reload && !frame_good) state_nxt = MEASURE;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign err_inc = (state == LOCKED) && (state_nxt != LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SEARCH;
            hs_d          <= 1'b1;
            vs_d          <= 1'b1;
            h_cnt         <= '0;
            v_cnt         <= '0;
            pending       <= 1'b0;
            line_bad      <= 1'b0;
            err_cnt       <= '0;
            frame_start_r <= 1'b0;
        end else begin
            state <= state_nxt;
            hs_d  <= bus.vga_hs;
            vs_d  <= bus.vga_vs;

            if (hs_ev)                h_cnt <= '0;
            else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 10'd1;

            if (v_reload)                       v_cnt <= '0;
            else if (hs_ev && v_cnt != CNT_MAX) v_cnt <= v_cnt + 10'd1;

            if (v_reload)   pending <= 1'b0;
            else if (vs_ev) pending <= 1'b1;

            if (v_reload)      line_bad <= 1'b0;
            else if (line_err) line_bad <= 1'b1;

            if (err_inc && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;

            frame_start_r <= v_reload && (state_nxt == LOCKED);
        end
    end

    assign bus.h_count     = h_cnt;
    assign bus.v_count     = v_cnt;
    assign bus.locked      = (state == LOCKED);
    assign bus.err_count   = err_cnt;
    assign bus.frame_start = frame_start_r;
    assign bus.active      = (state == LOCKED) &&
                             (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                             (v_cnt >= V_LO) && (v_cnt < V_HI);
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed self-checking bench for vga_sync_decoder
module tb_vga_sync_decoder;
    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HAS = 8;
    localparam int HA  = 24;
    localparam int VAS = 3;
    localparam int VA  = 6;
    localparam int HSW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS),
        .H_ACTIVE(HA), .V_ACT_START(VAS), .V_ACTIVE(VA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fs_count = 0;
    int fs_h = -1;
    int fs_v = -1;
    int act_count = 0;
    int act_h = -1;
    int act_v = -1;
    int snap;

    always @(negedge clk) begin
        if (bus.frame_start) begin
            fs_count++;
            fs_h = int'(bus.h_count);
            fs_v = int'(bus.v_count);
        end
        if (bus.active) begin
            if (act_h < 0) begin
                act_h = int'(bus.h_count);
                act_v = int'(bus.v_count);
            end
            act_count++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int len, input int line, input bit early_vs);
        for (int i = 0; i < len; i++) begin
            bus.vga_hs = (i < HSW) ? 1'b0 : 1'b1;
            bus.vga_vs = (line < 2 || (early_vs && i >= len - 10)) ? 1'b0 : 1'b1;
            step();
        end
    endtask

    task automatic drive_lines(input int first, input int last);
        for (int l = first; l <= last; l++) drive_line(HT, l, 1'b0);
    endtask

    initial begin
        bus.vga_hs = 1'b1;
        bus.vga_vs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_h",      int'(bus.h_count), 0);
        check("rst_v",      int'(bus.v_count), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_active", int'(bus.active), 0);
        check("rst_fs",     int'(bus.frame_start), 0);
        check("rst_err",    int'(bus.err_count), 0);

        reset = 1'b0;
        repeat (5) step();

        // frame A: first V-reload, SEARCH -> MEASURE
        drive_lines(0, VT - 1);
        check("a_locked", int'(bus.locked), 0);
        check("a_h",      int'(bus.h_count), HT - 1);
        check("a_v",      int'(bus.v_count), VT - 1);

        // frame B: second V-reload locks
        drive_line(HT, 0, 1'b0);
        check("b_locked", int'(bus.locked), 1);
        check("b_fs_cnt", fs_count, 1);
        check("b_fs_h",   fs_h, 0);
        check("b_fs_v",   fs_v, 0);
        check("b_err",    int'(bus.err_count), 0);
        snap = act_count;
        drive_lines(1, VT - 2);
        drive_line(HT, VT - 1, 1'b1);   // VS falls 10 clocks before the next HS
        check("act_cycles",   act_count - snap, HA * VA);
        check("act_first_h",  act_h, HAS);
        check("act_first_v",  act_v, VAS);
        check("early_vs_v",   int'(bus.v_count), VT - 1);

        // frame C: reload happens on the HS edge
        drive_line(HT, 0, 1'b0);
        check("c_v",      int'(bus.v_count), 0);
        check("c_locked", int'(bus.locked), 1);
        check("c_fs_cnt", fs_count, 2);
        drive_lines(1, VT - 1);

        // frame D: line 3 one clock short
        drive_lines(0, 2);
        drive_line(HT - 1, 3, 1'b0);
        check("short_pre_locked", int'(bus.locked), 1);
        check("d_fs_cnt",         fs_count, 3);
        drive_line(HT, 4, 1'b0);
        check("short_locked", int'(bus.locked), 0);
        check("short_err",    int'(bus.err_count), 1);
        drive_lines(5, VT - 1);
        drive_lines(0, VT - 1);         // frame E: MEASURE
        check("e_locked", int'(bus.locked), 0);
        drive_line(HT, 0, 1'b0);        // frame F: relock
        check("f_locked", int'(bus.locked), 1);
        check("f_err",    int'(bus.err_count), 1);
        check("f_fs_cnt", fs_count, 4);

        // frame F cut to VT-1 lines
        drive_lines(1, VT - 2);
        drive_line(HT, 0, 1'b0);
        check("shortf_locked", int'(bus.locked), 0);
        check("shortf_err",    int'(bus.err_count), 2);
        check("shortf_fs_cnt", fs_count, 4);
        drive_lines(1, VT - 1);
        drive_line(HT, 0, 1'b0);
        check("h_locked", int'(bus.locked), 1);
        check("h_fs_cnt", fs_count, 5);

        // hsync stops
        bus.vga_hs = 1'b1;
        bus.vga_vs = 1'b1;
        step();
        check("to_h",      int'(bus.h_count), HT);
        check("to_locked", int'(bus.locked), 0);
        check("to_err",    int'(bus.err_count), 3);
        repeat (1100) step();
        check("sat_h",   int'(bus.h_count), 1023);
        check("sat_err", int'(bus.err_count), 3);

        // relock, then reset mid-line in the active region
        drive_lines(0, VT - 1);
        drive_line(HT, 0, 1'b0);
        check("relock", int'(bus.locked), 1);
        drive_lines(1, VAS - 1);
        drive_line(20, VAS, 1'b0);
        check("pre_rst_active", int'(bus.active), 1);
        check("pre_rst_h",      int'(bus.h_count), 19);
        reset = 1'b1;
        #2;
        check("mid_rst_h",      int'(bus.h_count), 0);
        check("mid_rst_v",      int'(bus.v_count), 0);
        check("mid_rst_locked", int'(bus.locked), 0);
        check("mid_rst_active", int'(bus.active), 0);
        check("mid_rst_fs",     int'(bus.frame_start), 0);
        check("mid_rst_err",    int'(bus.err_count), 0);
        reset = 1'b0;
        repeat (3) step();
        check("post_rst_h",      int'(bus.h_count), 3);
        check("post_rst_v",      int'(bus.v_count), 0);
        check("post_rst_locked", int'(bus.locked), 0);
        bus.vga_hs = 1'b0;
        step();
        check("real_edge_h", int'(bus.h_count), 0);
        check("real_edge_v", int'(bus.v_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
